// File: rtl/axi_llc_tag_lookup.sv
// -----------------------------------------------------------------------------
// axi_llc_tag_lookup
// Tag-lookup controller in front of the per-way tag SRAMs (one macro per way,
// shared address/data/enable). After reset it clears every entry, then serves
// one lookup at a time.
//
// For each lookup it:
//   - reads all ways in parallel and compares the stored tags,
//   - reports hit/miss, the hit or victim way, and eviction info,
//   - writes back the updated entry: allocate on a miss, set dirty on a write
//     hit to a clean line.
//
// Stored entry layout: {valid, dirty, tag}.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   init_done_o          high once the clear sweep has finished
//   req_*                lookup request (valid/ready, index, tag, write flag)
//   resp_*               lookup result (valid/ready, hit, way, evict, evict tag)
//   sram_req_o           per-way SRAM request
//   sram_we_o            shared write enable
//   sram_addr_o          shared address
//   sram_wdata_o         shared write entry
//   sram_be_o            shared byte enables
//   sram_rdata_i         per-way read data, valid Latency cycles after a read
// -----------------------------------------------------------------------------
module axi_llc_tag_lookup #(
    parameter int unsigned NumLines = 256,
    parameter int unsigned NumWays  = 4,
    parameter int unsigned TagWidth = 20,
    parameter int unsigned Latency  = 1,
    localparam int unsigned IndexWidth = $clog2(NumLines),
    localparam int unsigned EntryWidth = TagWidth + 2,
    localparam int unsigned BeWidth    = (EntryWidth + 7) / 8,
    localparam int unsigned WayWidth   = (NumWays > 1) ? $clog2(NumWays) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    output logic                                init_done_o,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [IndexWidth-1:0]               req_index_i,
    input  logic [TagWidth-1:0]                 req_tag_i,
    input  logic                                req_write_i,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic                                resp_hit_o,
    output logic [WayWidth-1:0]                 resp_way_o,
    output logic                                resp_evict_o,
    output logic [TagWidth-1:0]                 resp_evict_tag_o,
    output logic [NumWays-1:0]                  sram_req_o,
    output logic                                sram_we_o,
    output logic [IndexWidth-1:0]               sram_addr_o,
    output logic [EntryWidth-1:0]               sram_wdata_o,
    output logic [BeWidth-1:0]                  sram_be_o,
    input  logic [NumWays-1:0][EntryWidth-1:0]  sram_rdata_i
);

    localparam int unsigned LatWidth = $clog2(Latency + 1);

    localparam logic [2:0] StInit   = 3'd0;
    localparam logic [2:0] StIdle   = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StResp   = 3'd3;
    localparam logic [2:0] StUpdate = 3'd4;

    logic [2:0]            state_q,     state_d;
    logic [IndexWidth-1:0] sweep_q,     sweep_d;
    logic                  init_done_q, init_done_d;
    logic [LatWidth-1:0]   lat_q,       lat_d;
    logic [IndexWidth-1:0] index_q,     index_d;
    logic [TagWidth-1:0]   tag_q,       tag_d;
    logic                  write_q,     write_d;
    logic                  hit_q,       hit_d;
    logic                  hit_dirty_q, hit_dirty_d;
    logic [WayWidth-1:0]   way_q,       way_d;
    logic                  evict_q,     evict_d;
    logic [TagWidth-1:0]   evict_tag_q, evict_tag_d;
    logic [WayWidth-1:0]   victim_q,    victim_d;

    logic                  lk_hit;
    logic                  lk_dirty;
    logic [WayWidth-1:0]   lk_way;
    logic [EntryWidth-1:0] victim_entry;

    // Tag compare across all ways; the first matching way (lowest index) wins.
    always_comb begin
        lk_hit   = 1'b0;
        lk_dirty = 1'b0;
        lk_way   = '0;
        for (int unsigned w = 0; w < NumWays; w++) begin
            if (!lk_hit && sram_rdata_i[w][EntryWidth-1] &&
                (sram_rdata_i[w][TagWidth-1:0] == tag_q)) begin
                lk_hit   = 1'b1;
                lk_dirty = sram_rdata_i[w][EntryWidth-2];
                lk_way   = WayWidth'(w);
            end
        end
    end

    assign victim_entry = sram_rdata_i[victim_q];

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        lat_d       = lat_q;
        index_d     = index_q;
        tag_d       = tag_q;
        write_d     = write_q;
        hit_d       = hit_q;
        hit_dirty_d = hit_dirty_q;
        way_d       = way_q;
        evict_d     = evict_q;
        evict_tag_d = evict_tag_q;
        victim_d    = victim_q;

        req_ready_o  = 1'b0;
        sram_req_o   = '0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;

        case (state_q)
            StInit: begin
                sram_req_o  = '1;
                sram_we_o   = 1'b1;
                sram_addr_o = sweep_q;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == IndexWidth'(NumLines - 1)) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    sram_req_o  = '1;
                    sram_addr_o = req_index_i;
                    index_d     = req_index_i;
                    tag_d       = req_tag_i;
                    write_d     = req_write_i;
                    lat_d       = LatWidth'(Latency);
                    state_d     = StWait;
                end
            end
            StWait: begin
                lat_d = lat_q - 1'b1;
                // A count of 1 marks the cycle the read data becomes valid.
                if (lat_q == LatWidth'(1)) begin
                    hit_d       = lk_hit;
                    hit_dirty_d = lk_dirty;
                    way_d       = lk_hit ? lk_way : victim_q;
                    evict_d     = !lk_hit && victim_entry[EntryWidth-1] &&
                                  victim_entry[EntryWidth-2];
                    evict_tag_d = victim_entry[TagWidth-1:0];
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    if (!hit_q) begin
                        state_d  = StUpdate;
                        victim_d = (victim_q == WayWidth'(NumWays - 1)) ? '0 : victim_q + 1'b1;
                    end else if (write_q && !hit_dirty_q) begin
                        state_d = StUpdate;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StUpdate: begin
                // Both update cases (allocate, write hit) store dirty = write flag.
                sram_req_o         = '0;
                sram_req_o[way_q]  = 1'b1;
                sram_we_o          = 1'b1;
                sram_addr_o        = index_q;
                sram_wdata_o       = {1'b1, write_q, tag_q};
                state_d            = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            lat_q       <= '0;
            index_q     <= '0;
            tag_q       <= '0;
            write_q     <= 1'b0;
            hit_q       <= 1'b0;
            hit_dirty_q <= 1'b0;
            way_q       <= '0;
            evict_q     <= 1'b0;
            evict_tag_q <= '0;
            victim_q    <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            lat_q       <= lat_d;
            index_q     <= index_d;
            tag_q       <= tag_d;
            write_q     <= write_d;
            hit_q       <= hit_d;
            hit_dirty_q <= hit_dirty_d;
            way_q       <= way_d;
            evict_q     <= evict_d;
            evict_tag_q <= evict_tag_d;
            victim_q    <= victim_d;
        end
    end

    assign init_done_o      = init_done_q;
    assign resp_valid_o     = (state_q == StResp);
    assign resp_hit_o       = hit_q;
    assign resp_way_o       = way_q;
    assign resp_evict_o     = evict_q;
    assign resp_evict_tag_o = evict_tag_q;
    assign sram_be_o        = '1;

endmodule

// File: tb/tb_axi_llc_tag_lookup.sv
// -----------------------------------------------------------------------------
// tb_axi_llc_tag_lookup
// Directed bench for axi_llc_tag_lookup.
//
// Two DUT instances, each paired with a behavioural tag SRAM model:
//   - dut : defaults (256 lines, Latency 1)
//   - dut3: 16 lines, Latency 3 (response timing only)
// -----------------------------------------------------------------------------
module tb_axi_llc_tag_lookup;

    typedef struct {
        logic        hit;
        logic [1:0]  way;
        logic        evict;
        logic [19:0] evict_tag;
        int          lat;
        logic        valid_after;
        logic [3:0]  ureq;
        logic        uwe;
        logic [7:0]  uaddr;
        logic [21:0] uwdata;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (Latency 1) ----------------
    logic              init_done, req_valid, req_ready, req_write;
    logic [7:0]        req_index;
    logic [19:0]       req_tag;
    logic              resp_valid, resp_ready, resp_hit, resp_evict;
    logic [1:0]        resp_way;
    logic [19:0]       resp_evict_tag;
    logic [3:0]        sram_req;
    logic              sram_we;
    logic [7:0]        sram_addr;
    logic [21:0]       sram_wdata;
    logic [2:0]        sram_be;
    logic [3:0][21:0]  sram_rdata;
    logic [21:0]       mem [0:3][0:255];

    axi_llc_tag_lookup #(.NumLines(256), .NumWays(4), .TagWidth(20), .Latency(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_index_i(req_index),
        .req_tag_i(req_tag), .req_write_i(req_write),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
        .resp_way_o(resp_way), .resp_evict_o(resp_evict), .resp_evict_tag_o(resp_evict_tag),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (sram_req[w]) begin
                if (sram_we) mem[w][sram_addr] <= sram_wdata;
                else         sram_rdata[w]     <= mem[w][sram_addr];
            end
        end
    end

    // ---------------- second DUT (Latency 3, 16 lines) ----------------
    logic              init_done3, req_valid3, req_ready3;
    logic [3:0]        req_index3;
    logic [19:0]       req_tag3;
    logic              resp_valid3, resp_ready3, resp_hit3, resp_evict3;
    logic [1:0]        resp_way3;
    logic [19:0]       resp_evict_tag3;
    logic [3:0]        sram_req3;
    logic              sram_we3;
    logic [3:0]        sram_addr3;
    logic [21:0]       sram_wdata3;
    logic [2:0]        sram_be3;
    logic [3:0][21:0]  p1, p2, p3;
    logic [21:0]       mem3 [0:3][0:15];

    axi_llc_tag_lookup #(.NumLines(16), .NumWays(4), .TagWidth(20), .Latency(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done3),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_index_i(req_index3),
        .req_tag_i(req_tag3), .req_write_i(1'b0),
        .resp_valid_o(resp_valid3), .resp_ready_i(resp_ready3), .resp_hit_o(resp_hit3),
        .resp_way_o(resp_way3), .resp_evict_o(resp_evict3), .resp_evict_tag_o(resp_evict_tag3),
        .sram_req_o(sram_req3), .sram_we_o(sram_we3), .sram_addr_o(sram_addr3),
        .sram_wdata_o(sram_wdata3), .sram_be_o(sram_be3), .sram_rdata_i(p3)
    );

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (sram_req3[w]) begin
                if (sram_we3) mem3[w][sram_addr3] <= sram_wdata3;
                else          p1[w]               <= mem3[w][sram_addr3];
            end
        end
        p2 <= p1;
        p3 <= p2;
    end

    // Drives one lookup on the main DUT from IDLE through handshake and any
    // UPDATE cycle; returns what was observed. Inputs change on negedges.
    task automatic lookup(input logic [7:0] idx, input logic [19:0] tag,
                          input logic wr, output res_t r);
        int cnt;
        req_valid = 1'b1; req_index = idx; req_tag = tag; req_write = wr;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        r.lat       = cnt + 1;
        r.hit       = resp_hit;
        r.way       = resp_way;
        r.evict     = resp_evict;
        r.evict_tag = resp_evict_tag;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        r.valid_after = resp_valid;
        r.ureq   = sram_req;
        r.uwe    = sram_we;
        r.uaddr  = sram_addr;
        r.uwdata = sram_wdata;
        if (sram_req != 4'h0) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [37:0] got, exp;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({init_done, req_ready, resp_valid, resp_hit, resp_evict} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_status: got %b want 00000",
                     {init_done, req_ready, resp_valid, resp_hit, resp_evict});
        end
        n_cmp++;
        if ({sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== {4'hF, 1'b1, 8'h00, 22'h0, 3'b111}) begin
            n_bad++;
            $display("FAIL reset_sram: got req=%h we=%b addr=%h wd=%h be=%b want F 1 00 000000 111",
                     sram_req, sram_we, sram_addr, sram_wdata, sram_be);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            got = {req_ready, init_done, sram_req, sram_we, sram_addr, sram_wdata};
            exp = {1'b0, 1'b0, 4'hF, 1'b1, i[7:0], 22'h0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL init_cycle_%0d: got %h want %h", i, got, exp);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({init_done, req_ready, sram_req} !== {1'b1, 1'b1, 4'h0}) begin
            n_bad++;
            $display("FAIL init_done_after_256: got done=%b ready=%b req=%h want 1 1 0",
                     init_done, req_ready, sram_req);
        end
        n_cmp++;
        if (mem[0][0] !== 22'h0 || mem[3][255] !== 22'h0 || mem[2][128] !== 22'h0) begin
            n_bad++;
            $display("FAIL init_clear: got %h %h %h want 0", mem[0][0], mem[3][255], mem[2][128]);
        end
    endtask

    task automatic test_miss_then_hit();
        res_t r;
        lookup(8'd5, 20'h00123, 1'b0, r);
        n_cmp++;
        if ({r.hit, r.way, r.evict, r.lat} !== {1'b0, 2'd0, 1'b0, 32'd2}) begin
            n_bad++;
            $display("FAIL miss_resp: got hit=%b way=%0d ev=%b lat=%0d want 0 0 0 2", r.hit, r.way, r.evict, r.lat);
        end
        n_cmp++;
        if ({r.valid_after, r.ureq, r.uwe, r.uaddr, r.uwdata} !== {1'b0, 4'b0001, 1'b1, 8'd5, 22'h200123}) begin
            n_bad++;
            $display("FAIL miss_update: got v=%b req=%b we=%b addr=%h wd=%h want 0 0001 1 05 200123",
                     r.valid_after, r.ureq, r.uwe, r.uaddr, r.uwdata);
        end
        lookup(8'd5, 20'h00123, 1'b0, r);
        n_cmp++;
        if ({r.hit, r.way, r.ureq} !== {1'b1, 2'd0, 4'h0}) begin
            n_bad++;
            $display("FAIL repeat_hit: got hit=%b way=%0d upd=%b want 1 0 0000", r.hit, r.way, r.ureq);
        end
    endtask

    task automatic test_write_hit();
        res_t r;
        lookup(8'd5, 20'h00123, 1'b1, r);
        n_cmp++;
        if ({r.hit, r.way, r.ureq, r.uwe, r.uaddr, r.uwdata} !== {1'b1, 2'd0, 4'b0001, 1'b1, 8'd5, 22'h300123}) begin
            n_bad++;
            $display("FAIL write_hit_clean: got hit=%b way=%0d req=%b we=%b addr=%h wd=%h want 1 0 0001 1 05 300123",
                     r.hit, r.way, r.ureq, r.uwe, r.uaddr, r.uwdata);
        end
        lookup(8'd5, 20'h00123, 1'b1, r);
        n_cmp++;
        if ({r.hit, r.way, r.ureq} !== {1'b1, 2'd0, 4'h0}) begin
            n_bad++;
            $display("FAIL write_hit_dirty: got hit=%b way=%0d upd=%b want 1 0 0000", r.hit, r.way, r.ureq);
        end
    endtask

    task automatic test_dirty_evict();
        res_t r;
        logic [19:0] tags [4];
        tags = '{20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD};
        // Victim pointer is at 1 here; three misses bring it back to 0.
        for (int i = 0; i < 3; i++) begin
            lookup(8'd9, 20'(i + 1), 1'b0, r);
            n_cmp++;
            if ({r.hit, r.way} !== {1'b0, 2'(i + 1)}) begin
                n_bad++;
                $display("FAIL victim_rotate_%0d: got hit=%b way=%0d want 0 %0d", i, r.hit, r.way, i + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            lookup(8'd7, tags[i], 1'b1, r);
            n_cmp++;
            if ({r.hit, r.way, r.evict, r.ureq, r.uwdata} !== {1'b0, 2'(i), 1'b0, 4'(1 << i), {2'b11, tags[i]}}) begin
                n_bad++;
                $display("FAIL fill_%0d: got hit=%b way=%0d ev=%b req=%b wd=%h want 0 %0d 0 %b %h",
                         i, r.hit, r.way, r.evict, r.ureq, r.uwdata, i, 4'(1 << i), {2'b11, tags[i]});
            end
        end
        lookup(8'd7, 20'h0EEEE, 1'b0, r);
        n_cmp++;
        if ({r.hit, r.way, r.evict, r.evict_tag, r.ureq, r.uwdata} !== {1'b0, 2'd0, 1'b1, 20'h0AAAA, 4'b0001, 22'h20EEEE}) begin
            n_bad++;
            $display("FAIL evict_A: got hit=%b way=%0d ev=%b evt=%h req=%b wd=%h want 0 0 1 0aaaa 0001 20eeee",
                     r.hit, r.way, r.evict, r.evict_tag, r.ureq, r.uwdata);
        end
        lookup(8'd7, 20'h0FFFF, 1'b0, r);
        n_cmp++;
        if ({r.hit, r.way, r.evict, r.evict_tag} !== {1'b0, 2'd1, 1'b1, 20'h0BBBB}) begin
            n_bad++;
            $display("FAIL evict_B: got hit=%b way=%0d ev=%b evt=%h want 0 1 1 0bbbb",
                     r.hit, r.way, r.evict, r.evict_tag);
        end
        lookup(8'd7, 20'h0DDDD, 1'b0, r);
        n_cmp++;
        if ({r.hit, r.way, r.evict, r.ureq} !== {1'b1, 2'd3, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL read_hit_dirty: got hit=%b way=%0d ev=%b upd=%b want 1 3 0 0000",
                     r.hit, r.way, r.evict, r.ureq);
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        logic [23:0] snap;
        req_valid = 1'b1; req_index = 8'd7; req_tag = 20'h12345; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if ({resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag} !== {1'b1, 1'b0, 2'd2, 1'b1, 20'h0CCCC}) begin
            n_bad++;
            $display("FAIL bp_resp: got v=%b hit=%b way=%0d ev=%b evt=%h want 1 0 2 1 0cccc",
                     resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag);
        end
        snap = {resp_hit, resp_way, resp_evict, resp_evict_tag};
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({resp_valid, req_ready, sram_req, resp_hit, resp_way, resp_evict, resp_evict_tag} !== {1'b1, 1'b0, 4'h0, snap}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b req=%b resp=%h want 1 0 0000 %h",
                         i, resp_valid, req_ready, sram_req, {resp_hit, resp_way, resp_evict, resp_evict_tag}, snap);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++;
        if ({resp_valid, sram_req, sram_addr, sram_wdata} !== {1'b0, 4'b0100, 8'd7, 22'h212345}) begin
            n_bad++;
            $display("FAIL bp_update: got v=%b req=%b addr=%h wd=%h want 0 0100 07 212345",
                     resp_valid, sram_req, sram_addr, sram_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_latency3();
        int cnt;
        cnt = 0;
        while (!init_done3 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if ({init_done3, req_ready3} !== 2'b11) begin
            n_bad++;
            $display("FAIL lat3_init: got done=%b rdy=%b want 1 1", init_done3, req_ready3);
        end
        req_valid3 = 1'b1; req_index3 = 4'd2; req_tag3 = 20'h00055;
        @(negedge clk);
        req_valid3 = 1'b0;
        cnt = 0;
        while (!resp_valid3 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt + 1 !== 4 || resp_hit3 !== 1'b0) begin
            n_bad++;
            $display("FAIL lat3_timing: got lat=%0d hit=%b want 4 0", cnt + 1, resp_hit3);
        end
        resp_ready3 = 1'b1;
        @(negedge clk);
        resp_ready3 = 1'b0;
        n_cmp++;
        if ({resp_valid3, sram_req3, sram_wdata3} !== {1'b0, 4'b0001, 22'h200055}) begin
            n_bad++;
            $display("FAIL lat3_update: got v=%b req=%b wd=%h want 0 0001 200055", resp_valid3, sram_req3, sram_wdata3);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        res_t r;
        int cnt;
        logic seen_valid;
        req_valid = 1'b1; req_index = 8'd5; req_tag = 20'h00777; req_write = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if ({resp_valid, req_ready, sram_req} !== {1'b0, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL rw_in_wait: got v=%b rdy=%b req=%b want 0 0 0000", resp_valid, req_ready, sram_req);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({resp_valid, init_done, sram_req, sram_we, sram_addr} !== {1'b0, 1'b0, 4'hF, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL rw_during_reset: got v=%b done=%b req=%b we=%b addr=%h want 0 0 1111 1 00",
                     resp_valid, init_done, sram_req, sram_we, sram_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (sram_addr !== 8'd0) begin
            n_bad++;
            $display("FAIL rw_sweep0: got addr=%h want 00", sram_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({sram_addr, sram_we} !== {8'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL rw_sweep1: got addr=%h we=%b want 01 1", sram_addr, sram_we);
        end
        cnt = 0;
        seen_valid = 1'b0;
        while (!init_done && cnt < 300) begin
            seen_valid = seen_valid | resp_valid;
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if ({init_done, seen_valid, cnt} !== {1'b1, 1'b0, 32'd255}) begin
            n_bad++;
            $display("FAIL rw_reinit: got done=%b resp_seen=%b cycles=%0d want 1 0 255", init_done, seen_valid, cnt);
        end
        lookup(8'd5, 20'h00123, 1'b0, r);
        n_cmp++;
        if ({r.hit, r.way, r.evict} !== {1'b0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL rw_victim0: got hit=%b way=%0d ev=%b want 0 0 0", r.hit, r.way, r.evict);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_index = '0; req_tag = '0; req_write = 1'b0; resp_ready = 1'b0;
        req_valid3 = 1'b0; req_index3 = '0; req_tag3 = '0; resp_ready3 = 1'b0;
        test_reset();
        test_miss_then_hit();
        test_write_hit();
        test_dirty_evict();
        test_backpressure();
        test_latency3();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
